// File: rtl/rv16_mul_arbiter.sv
// rv16_mul_arbiter: two-requester round-robin front end for a shared
// multi-cycle multiplier. Each request is issued once, and the arbiter waits
// for the result or a timeout. The result is then held until the owning
// requester takes it.
module rv16_mul_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req_valid,
  input  logic        r1_req_valid,
  output logic        r0_req_ready,
  output logic        r1_req_ready,
  input  logic [31:0] r0_op_a,
  input  logic [31:0] r0_op_b,
  input  logic [31:0] r1_op_a,
  input  logic [31:0] r1_op_b,
  output logic        r0_rsp_valid,
  output logic        r1_rsp_valid,
  input  logic        r0_rsp_ready,
  input  logic        r1_rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mul_start,
  output logic [31:0] mul_op_a,
  output logic [31:0] mul_op_b,
  input  logic [31:0] mul_result,
  input  logic        mul_done,
  input  logic        mul_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Abort threshold, compared against the post-increment wait count.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic        ptr_reg, ptr_next;      // preferred requester (0 = r0)
  logic        grant_reg, grant_next;  // requester owning the current operation
  logic [31:0] op_a_reg, op_a_next;
  logic [31:0] op_b_reg, op_b_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] data_reg, data_next;
  logic        err_reg, err_next;
  logic        pick;                   // requester that would win this cycle

  assign rsp_data = data_reg;
  assign rsp_err  = err_reg;
  assign mul_op_a = op_a_reg;
  assign mul_op_b = op_b_reg;

  // Round-robin choice: r1 wins if it is alone, or if both ask and it is preferred.
  assign pick = r1_req_valid & (ptr_reg | ~r0_req_valid);

  // State and datapath registers; reset drops any in-flight operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      grant_reg <= 1'b0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and handshake outputs for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    op_a_next    = op_a_reg;
    op_b_next    = op_b_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    err_next     = err_reg;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    mul_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Ready is gated by rst_n so no acceptance is advertised while held in reset.
        if (rst_n && (r0_req_valid || r1_req_valid)) begin
          r0_req_ready = ~pick;
          r1_req_ready = pick;
          grant_next   = pick;
          op_a_next    = pick ? r1_op_a : r0_op_a;
          op_b_next    = pick ? r1_op_b : r0_op_b;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (!mul_busy) begin
          mul_start  = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (mul_done) begin
          data_next  = mul_result;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_next == TIMEOUT_CNT) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        r0_rsp_valid = ~grant_reg;
        r1_rsp_valid = grant_reg;
        if (grant_reg ? r1_rsp_ready : r0_rsp_ready) begin
          ptr_next   = ~grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv16_mul_arbiter.sv
// Directed testbench for rv16_mul_arbiter with a 3-cycle multiplier model.
module tb_rv16_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req_valid = 0, r1_req_valid = 0;
  logic        r0_req_ready, r1_req_ready;
  logic [31:0] r0_op_a = 0, r0_op_b = 0, r1_op_a = 0, r1_op_b = 0;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic        r0_rsp_ready = 1, r1_rsp_ready = 1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mul_start;
  logic [31:0] mul_op_a, mul_op_b, mul_result;
  logic        mul_done;
  logic        mul_busy = 0;

  // Multiplier model controls.
  logic        suppress = 0;
  logic        inject = 0;
  logic [31:0] inject_val = 0;
  logic        p1 = 0, p2 = 0, p3 = 0;
  logic [31:0] res1 = 0, res2 = 0, res3 = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv16_mul_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
    .r0_req_ready(r0_req_ready), .r1_req_ready(r1_req_ready),
    .r0_op_a(r0_op_a), .r0_op_b(r0_op_b), .r1_op_a(r1_op_a), .r1_op_b(r1_op_b),
    .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_result(mul_result), .mul_done(mul_done), .mul_busy(mul_busy)
  );

  // Multiplier: start sampled when not busy; done pulses 3 cycles after the start cycle.
  always @(posedge clk) begin
    p1   <= mul_start & ~mul_busy;
    res1 <= mul_op_a * mul_op_b;
    p2   <= p1;
    res2 <= res1;
    p3   <= p2;
    res3 <= res2;
  end
  assign mul_done   = (p3 & ~suppress) | inject;
  assign mul_result = inject ? inject_val : res3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from the current negedge; returns #1 after the negedge
  // of the first cycle with a response valid.
  task automatic do_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input bit exp_e, input int exp_lat,
                        input string tag);
    int  k;
    bit  seen;
    if (id == 1'b0) begin
      r0_req_valid = 1; r0_op_a = a; r0_op_b = b;
    end else begin
      r1_req_valid = 1; r1_op_a = a; r1_op_b = b;
    end
    #1;
    check({tag, "_ready"}, id ? r1_req_ready : r0_req_ready, 1);
    check({tag, "_other_ready"}, id ? r0_req_ready : r1_req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    r0_req_valid = 0;
    r1_req_valid = 0;
    seen = 0;
    k = 1;
    while (!seen && k <= 40) begin
      #1;
      if (k == 1) begin
        check({tag, "_start"}, mul_start, 1);
        check({tag, "_op_a"}, mul_op_a, a);
        check({tag, "_op_b"}, mul_op_b, b);
      end
      if (r0_rsp_valid || r1_rsp_valid) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_rsp_valid"}, id ? r1_rsp_valid : r0_rsp_valid, 1);
    check({tag, "_other_rsp_valid"}, id ? r0_rsp_valid : r1_rsp_valid, 0);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_err"}, rsp_err, exp_e);
    $display("txn %s: r%0d %h x %h -> data %h err %0d latency %0d", tag, id, a, b, rsp_data, rsp_err, k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last, g;
    bit cur;

    vecs[0] = '{1'b0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{1'b0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
    vecs[6] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_r0_req_ready", r0_req_ready, 0);
    check("rst_r1_req_ready", r1_req_ready, 0);
    check("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mul_op", {mul_op_a[15:0], mul_op_b[15:0]}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Single transactions from the vector table, results taken immediately.
    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 5, $sformatf("vec%0d", i));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_rsp_cleared", i), {r0_rsp_valid, r1_rsp_valid}, 0);
      @(negedge clk);
    end

    // Contention from reset: grants alternate r0, r1, r0, r1, six cycles apart.
    do_reset();
    r0_op_a = 2; r0_op_b = 3; r1_op_a = 4; r1_op_b = 5;
    r0_req_valid = 1; r1_req_valid = 1;
    cyc = 0; last = 0; g = 0; cur = 0;
    while (g < 4 && cyc < 200) begin
      #1;
      check("cont_ready_exclusive", r0_req_ready & r1_req_ready, 0);
      if (r0_req_ready || r1_req_ready) begin
        check($sformatf("cont_grant%0d", g), r1_req_ready, g % 2);
        if (g > 0) check($sformatf("cont_gap%0d", g), cyc - last, 6);
        cur = r1_req_ready;
        last = cyc;
        g++;
      end
      if (r0_rsp_valid || r1_rsp_valid) begin
        check("cont_owner", r1_rsp_valid, cur);
        check("cont_data", rsp_data, cur ? 32'd20 : 32'd6);
        $display("txn cont: r%0d data %h", cur, rsp_data);
      end
      @(negedge clk);
      cyc++;
    end
    check("cont_grants", g, 4);
    r0_req_valid = 0; r1_req_valid = 0;
    repeat (8) @(negedge clk);

    // Backpressure: r1 result held for 10 cycles while r0 waits.
    do_reset();
    r1_rsp_ready = 0;
    do_req(1'b1, 32'h0000_0100, 32'h0000_0003, 32'h0000_0300, 1'b0, 5, "bp");
    r0_req_valid = 1; r0_op_a = 5; r0_op_b = 6;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("bp_valid%0d", i), r1_rsp_valid, 1);
      check($sformatf("bp_data%0d", i), rsp_data, 32'h0000_0300);
      check($sformatf("bp_r0_ready%0d", i), r0_req_ready, 0);
      @(negedge clk);
    end
    r1_rsp_ready = 1;
    #1;
    check("bp_handshake_r0_ready", r0_req_ready, 0);
    @(negedge clk);
    #1;
    check("bp_next_r0_ready", r0_req_ready, 1);
    @(negedge clk);
    r0_req_valid = 0;
    repeat (8) @(negedge clk);

    // Timeout: done suppressed, abort 8 cycles after WAIT entry, late done ignored.
    suppress = 1;
    r0_rsp_ready = 0;
    do_req(1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b1, 10, "timeout");
    @(negedge clk);
    inject = 1; inject_val = 32'h1234_5678;
    @(negedge clk);
    inject = 0;
    #1;
    check("to_late_valid", r0_rsp_valid, 1);
    check("to_late_data", rsp_data, 0);
    check("to_late_err", rsp_err, 1);
    r0_rsp_ready = 1;
    @(negedge clk);
    suppress = 0;
    @(negedge clk);

    // Busy multiplier: start held off until busy drops.
    mul_busy = 1;
    r1_req_valid = 1; r1_op_a = 7; r1_op_b = 9;
    #1;
    check("busy_ready", r1_req_ready, 1);
    @(negedge clk);
    r1_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("busy_no_start%0d", i), mul_start, 0);
      @(negedge clk);
    end
    mul_busy = 0;
    #1;
    check("busy_start", mul_start, 1);
    check("busy_op_a", mul_op_a, 7);
    cyc = 0;
    while (!r1_rsp_valid && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("busy_latency", cyc, 4);
    check("busy_data", rsp_data, 32'd63);
    $display("txn busy: r1 7 x 9 -> data %h latency %0d", rsp_data, cyc);
    @(negedge clk);
    @(negedge clk);

    // Reset during WAIT: everything clears, no response appears afterwards.
    r1_req_valid = 1; r1_op_a = 32'h11; r1_op_b = 32'h22;
    @(negedge clk);
    r1_req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rw_req_ready", {r0_req_ready, r1_req_ready}, 0);
    check("rw_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
    check("rw_mul_start", mul_start, 0);
    check("rw_rsp_data", rsp_data, 0);
    check("rw_rsp_err", rsp_err, 0);
    check("rw_mul_op_a", mul_op_a, 0);
    check("rw_mul_op_b", mul_op_b, 0);
    @(negedge clk);
    rst_n = 1;
    g = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (r0_rsp_valid || r1_rsp_valid) g++;
      @(negedge clk);
    end
    check("rw_no_rsp", g, 0);
    $display("txn reset_wait: in-flight r1 request discarded");
    do_req(1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0100, 1'b0, 5, "after_rst");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv16_mul_arbiter.md
RV16_MUL_ARBITER -- requirements
Module: rv16_mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, max cycles in WAIT before abort; legal range 4..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 r0_req_valid, r1_req_valid  input  1 each  requester has an operand pair.
REQ-005 r0_req_ready, r1_req_ready  output  1 each  operand pair accepted this cycle.
REQ-006 r0_op_a, r0_op_b, r1_op_a, r1_op_b  input  32 each  multiplicands.
REQ-007 r0_rsp_valid, r1_rsp_valid  output  1 each  result available.
REQ-008 r0_rsp_ready, r1_rsp_ready  input  1 each  requester takes result.
REQ-009 rsp_data  output  32  result, shared by both requesters, qualified by rN_rsp_valid.
REQ-010 rsp_err  output  1  result is a timeout abort; qualified by rN_rsp_valid.
REQ-011 mul_start  output  1; mul_op_a, mul_op_b  output  32 each  to multiplier.
REQ-012 mul_result  input  32; mul_done  input  1; mul_busy  input  1  from multiplier.

Function
REQ-013 The multiplier SHALL be treated as: start sampled when busy low; done pulses 1 cycle, 3 cycles after the start cycle; result is the low 32 bits of op_a*op_b, valid while done is high.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any rN_req_valid, grant one requester, assert its rN_req_ready combinationally in that cycle, latch its operands and grant id, go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester; if both are valid the preferred one wins; if only one is valid it wins.
REQ-017 The pointer SHALL move to the non-granted requester when a response handshake completes, so back-to-back contention alternates r0, r1, r0...
REQ-018 rN_req_ready SHALL be low in every state except IDLE, and never high for both requesters.
REQ-019 ISSUE: mul_start high with latched operands on mul_op_a/mul_op_b while mul_busy low; go to WAIT after the cycle mul_start is high; while mul_busy high, hold mul_start low and stay.
REQ-020 mul_op_a/mul_op_b SHALL hold the latched operands from ISSUE until return to IDLE.
REQ-021 WAIT: on mul_done, latch mul_result into rsp_data, rsp_err=0, go to RESP.
REQ-022 WAIT: an 8-bit counter SHALL clear on entry and increment each cycle; when it reaches TIMEOUT without mul_done, set rsp_data=0, rsp_err=1, go to RESP.
REQ-023 mul_done seen in any state other than WAIT SHALL be ignored.
REQ-024 RESP: assert rsp_valid of the granted requester only; hold rsp_data/rsp_err stable until its rsp_ready is high; on that handshake go to IDLE.
REQ-025 Latency: acceptance handshake in cycle T gives mul_start in T+1, mul_done in T+4, and rN_rsp_valid from T+5.
REQ-026 A new request SHALL NOT be accepted in the cycle the response handshake completes; earliest next acceptance is the following cycle (IDLE).
REQ-027 req_valid deasserted by a requester while not granted SHALL have no effect.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, pointer=r0, counter=0, all ready/valid/mul_start/rsp_err=0, rsp_data=0, mul_op_a/mul_op_b=0.
REQ-029 Reset mid-operation SHALL discard the in-flight request with no response; the requester reissues.

Verification
REQ-030 Single: r0 0x00010002 x 0x00030004 accepted at T -> mul_start at T+1, r0_rsp_valid at T+5, rsp_data=0x000A0008, rsp_err=0.
REQ-031 Contention: both valid from reset, rsp_ready tied high -> grants r0, r1, r0, r1; r1_rsp_valid never high during an r0 grant.
REQ-032 Backpressure: r1_rsp_ready low 10 cycles -> r1_rsp_valid and rsp_data stable for 10 cycles; r0_req_ready stays 0.
REQ-033 Timeout: mul_done forced low, TIMEOUT=8 -> rsp_valid 8 cycles after WAIT entry, rsp_data=0, rsp_err=1; a later mul_done is ignored.
REQ-034 Overflow: 0xFFFFFFFF x 0xFFFFFFFF -> rsp_data=0x00000001.
REQ-035 rst_n pulsed low during WAIT -> all outputs 0 immediately; no rsp_valid follows; next request completes normally.
